// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// The oversampling ratio and the vote tick positions live here so that a future transmitter can use them too.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } rx_state_t;

   localparam int OVS       = 16;
   localparam int SCNT_W    = $clog2(OVS);
   localparam int DATA_BITS = 8;

   // Tick numbers within a bit at which the line is sampled; the last one is also where the vote is taken.
   localparam logic [SCNT_W-1:0] TICK_A = SCNT_W'(7);
   localparam logic [SCNT_W-1:0] TICK_B = SCNT_W'(8);
   localparam logic [SCNT_W-1:0] TICK_C = SCNT_W'(9);

endpackage

// File: rtl/uart_baud_tick.sv
// Fractional rate generator: emits one-cycle ticks at a mean rate of RATE Hz
// from a CLK_HZ clock by means of a phase accumulator.
module uart_baud_tick #(
   parameter int CLK_HZ = 25_000_000,
   parameter int RATE   = 1_843_200
) (
   input  logic clk_25mhz,
   input  logic rst,
   output logic tick
);

   localparam logic [32:0] LIMIT = 33'(CLK_HZ);
   localparam logic [32:0] STEP  = 33'(RATE);

   logic [31:0] acc;
   logic [32:0] sum;
   logic [32:0] diff;

   // The extra top bit keeps the sum exact, so the compare is correct even for a full 32-bit accumulator.
   assign sum  = {1'b0, acc} + STEP;
   assign diff = sum - LIMIT;

   always_ff @(posedge clk_25mhz or posedge rst) begin
      if (rst) begin
         acc  <= '0;
         tick <= 1'b0;
      end else if (sum >= LIMIT) begin
         acc  <= diff[31:0];
         tick <= 1'b1;
      end else begin
         acc  <= sum[31:0];
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver: 16x oversampling with a 3-sample majority vote per bit.
// Received bytes go out through a single-entry valid/ready holding register.
module uart_rx_stream #(
   parameter int CLK_HZ = 25_000_000,
   parameter int BAUD   = 115200,
   parameter int OVS    = 16
) (
   input  logic       clk_25mhz,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   import uart_pkg::*;

   logic              sync1;
   logic              rxs;
   logic              tick;
   rx_state_t         state;
   rx_state_t         state_next;
   logic [SCNT_W-1:0] scnt;
   logic [SCNT_W-1:0] scnt_inc;
   logic [3:0]        bit_cnt;
   logic [7:0]        shift;
   logic              samp_a;
   logic              samp_b;
   logic              vote;
   logic              at_a;
   logic              at_b;
   logic              at_vote;
   logic              at_wrap;
   logic              deliver;
   logic              stop_bad;

   // rxd is asynchronous; both stages reset to the idle level so that reset cannot look like a start edge.
   always_ff @(posedge clk_25mhz or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= rxd;
         rxs   <= sync1;
      end
   end

   uart_baud_tick #(
      .CLK_HZ (CLK_HZ),
      .RATE   (BAUD * OVS)
   ) u_baud_tick (
      .clk_25mhz (clk_25mhz),
      .rst       (rst),
      .tick      (tick)
   );

   // The sample positions refer to the count that this tick produces, so the middle sample lands at the bit centre.
   assign scnt_inc = scnt + 1'b1;
   assign at_a     = tick && (scnt_inc == TICK_A);
   assign at_b     = tick && (scnt_inc == TICK_B);
   assign at_vote  = tick && (scnt_inc == TICK_C);
   assign at_wrap  = tick && (&scnt);
   assign vote     = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk_25mhz or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      deliver    = 1'b0;
      stop_bad   = 1'b0;
      case (state)
         IDLE: begin
            if (!rxs) begin
               state_next = START;
            end
         end
         START: begin
            if (at_vote && vote) begin
               state_next = IDLE;
            end else if (at_wrap) begin
               state_next = DATA;
            end
         end
         DATA: begin
            if (at_wrap && (bit_cnt == 4'(DATA_BITS))) begin
               state_next = STOP;
            end
         end
         STOP: begin
            // Return to IDLE at the vote rather than at the end of the bit, so that the next start edge is never missed.
            if (at_vote) begin
               if (vote) begin
                  deliver    = 1'b1;
                  state_next = IDLE;
               end else begin
                  stop_bad   = 1'b1;
                  state_next = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            if (rxs) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_25mhz or posedge rst) begin
      if (rst) begin
         scnt    <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         samp_a  <= 1'b1;
         samp_b  <= 1'b1;
      end else begin
         if (state == IDLE) begin
            scnt    <= '0;
            bit_cnt <= '0;
         end else if (tick) begin
            scnt <= scnt_inc;
         end
         if (at_a) begin
            samp_a <= rxs;
         end
         if (at_b) begin
            samp_b <= rxs;
         end
         if ((state == DATA) && at_vote) begin
            shift   <= {vote, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

   // A byte arriving while the previous one is still unread is dropped, so data never changes under a stalled consumer.
   always_ff @(posedge clk_25mhz or posedge rst) begin
      if (rst) begin
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= stop_bad;
         overrun   <= 1'b0;
         if (deliver) begin
            if (!valid || ready) begin
               data  <= shift;
               valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_stream.sv
// Self-checking bench for uart_rx_stream: drives serial frames from a bit-level model of the line,
// and a negedge monitor checks delivered bytes against a queue of expected bytes.
`timescale 1ns/1ps
module tb_uart_rx_stream;

   localparam int BIT_CLKS = 217;

   logic       clk_25mhz = 1'b0;
   logic       rst       = 1'b1;
   logic       rxd       = 1'b1;
   logic       ready     = 1'b0;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int         tests = 0;
   int         fails = 0;
   int         cycle = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_byte;
   bit         slot_full     = 1'b0;
   int         exp_frame_err = 0;
   int         exp_overrun   = 0;
   int         seen_frame_err = 0;
   int         seen_overrun   = 0;
   int         last_rise = 0;
   logic       prev_valid = 1'b0;
   int         start_cycle;
   logic [7:0] rand_byte;
   int         rand_clks;
   int         gap;
   int         waited;

   uart_rx_stream dut (
      .clk_25mhz (clk_25mhz),
      .rst       (rst),
      .rxd       (rxd),
      .data      (data),
      .valid     (valid),
      .ready     (ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #20 clk_25mhz = ~clk_25mhz;

   always @(posedge clk_25mhz) cycle++;

   task automatic checkOutput(input string name, input int actual, input int expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic waitClk(input int n);
      repeat (n) @(posedge clk_25mhz);
      #2;
   endtask

   // Reference model of the one-entry buffer: a good frame either fills the slot or, if it is still full and not being read, is lost.
   task automatic modelFrame(input logic [7:0] b, input bit stop_bit);
      if (!stop_bit) begin
         exp_frame_err++;
      end else if (slot_full && !ready) begin
         exp_overrun++;
      end else begin
         exp_q.push_back(b);
         slot_full = 1'b1;
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b, input int bit_clks, input bit stop_bit);
      logic [9:0] frame;
      frame = {stop_bit, b, 1'b0};
      modelFrame(b, stop_bit);
      for (int i = 0; i < 10; i++) begin
         rxd = frame[i];
         waitClk(bit_clks);
      end
      rxd = 1'b1;
   endtask

   // Monitor: pops the scoreboard on each handshake, checks that held data stays put, and counts the pulses.
   always @(negedge clk_25mhz) begin
      if (!rst) begin
         if (valid && !prev_valid) begin
            last_rise = cycle;
         end
         if (valid && !ready && exp_q.size() > 0) begin
            checkOutput("data_held", data, exp_q[0]);
         end
         if (valid && ready) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_byte", 1, 0);
            end else begin
               exp_byte = exp_q.pop_front();
               checkOutput("byte", data, exp_byte);
            end
            slot_full = 1'b0;
         end
         if (frame_err) seen_frame_err++;
         if (overrun) seen_overrun++;
      end
      prev_valid = valid;
   end

   initial begin
      waitClk(150_000);
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst   = 1'b1;
      rxd   = 1'b1;
      ready = 1'b0;
      waitClk(5);
      checkOutput("reset_valid", valid, 0);
      checkOutput("reset_data", data, 0);
      checkOutput("reset_frame_err", frame_err, 0);
      checkOutput("reset_overrun", overrun, 0);
      checkOutput("reset_busy", busy, 0);
      rst = 1'b0;
      waitClk(20);

      // Single byte with the consumer always ready; the delivery time is checked against 153 ticks after the start edge.
      ready = 1'b1;
      start_cycle = cycle;
      applyStimulus(8'h55, BIT_CLKS, 1'b1);
      waitClk(BIT_CLKS);
      checkOutput("latency_in_window",
                  int'((last_rise - start_cycle >= 2060) && (last_rise - start_cycle <= 2090)), 1);
      checkOutput("no_frame_err_55", seen_frame_err, exp_frame_err);
      checkOutput("no_overrun_55", seen_overrun, exp_overrun);

      // Two back-to-back frames with the consumer stalled.
      ready = 1'b0;
      applyStimulus(8'hA3, BIT_CLKS, 1'b1);
      applyStimulus(8'h3C, BIT_CLKS, 1'b1);
      waitClk(20);
      checkOutput("overrun_count", seen_overrun, exp_overrun);
      checkOutput("held_valid", valid, 1);
      checkOutput("held_data", data, 8'hA3);
      ready = 1'b1;
      waitClk(3);
      checkOutput("valid_dropped", valid, 0);
      checkOutput("overrun_queue_empty", exp_q.size(), 0);

      // Short low glitch: this is a false start.
      waitClk(100);
      rxd = 1'b0;
      waitClk(20);
      checkOutput("glitch_busy", busy, 1);
      waitClk(34);
      rxd = 1'b1;
      waitClk(96);
      checkOutput("glitch_back_idle", busy, 0);
      waitClk(300);
      checkOutput("glitch_no_valid", valid, 0);

      // Frame with a zero stop bit.
      applyStimulus(8'hC9, BIT_CLKS, 1'b0);
      waitClk(50);
      checkOutput("bad_stop_frame_err", seen_frame_err, exp_frame_err);
      checkOutput("bad_stop_no_valid", valid, 0);

      // Break: two frame times held low, expecting exactly one frame_err.
      rxd = 1'b0;
      modelFrame(8'h00, 1'b0);
      waitClk(20 * BIT_CLKS);
      checkOutput("break_busy", busy, 1);
      checkOutput("break_frame_err", seen_frame_err, exp_frame_err);
      rxd = 1'b1;
      waitClk(5);
      checkOutput("break_idle", busy, 0);
      checkOutput("break_no_valid", valid, 0);

      // Reset asserted in the middle of bit 4 of 0xF0.
      waitClk(200);
      rxd = 1'b0;
      waitClk(5 * BIT_CLKS);
      rxd = 1'b1;
      waitClk(BIT_CLKS / 2);
      rst = 1'b1;
      waitClk(1);
      checkOutput("midrst_valid", valid, 0);
      checkOutput("midrst_data", data, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_frame_err", frame_err, 0);
      checkOutput("midrst_overrun", overrun, 0);
      waitClk(5);
      rst = 1'b0;
      waitClk(300);
      checkOutput("post_reset_idle", busy, 0);
      applyStimulus(8'h7E, BIT_CLKS, 1'b1);
      waitClk(BIT_CLKS);

      // Sender clock about 3% fast and then about 3% slow.
      applyStimulus(8'h81, 211, 1'b1);
      waitClk(BIT_CLKS);
      applyStimulus(8'h81, 223, 1'b1);
      waitClk(BIT_CLKS);
      checkOutput("skew_frame_err", seen_frame_err, exp_frame_err);

      // Random bytes at slightly skewed rates, often with no idle time between them.
      for (int k = 0; k < 16; k++) begin
         rand_byte = 8'($urandom_range(0, 255));
         rand_clks = $urandom_range(213, 221);
         applyStimulus(rand_byte, rand_clks, 1'b1);
         gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 400);
         if (gap > 0) waitClk(gap);
      end

      waited = 0;
      while (exp_q.size() > 0 && waited < 5000) begin
         waitClk(1);
         waited++;
      end
      waitClk(20);
      checkOutput("drain_queue_empty", exp_q.size(), 0);
      checkOutput("total_frame_err", seen_frame_err, exp_frame_err);
      checkOutput("total_overrun", seen_overrun, exp_overrun);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
